// File: rtl/seq_pkg.sv
// Shared types for the step sequencer: note codes, FSM states and pattern entries.
package seq_pkg;

    localparam logic [2:0] NOTE_C4 = 3'b000;
    localparam logic [2:0] NOTE_D4 = 3'b001;
    localparam logic [2:0] NOTE_E4 = 3'b011;
    localparam logic [2:0] NOTE_F4 = 3'b100;
    localparam logic [2:0] NOTE_G4 = 3'b110;
    localparam logic [2:0] NOTE_A4 = 3'b101;
    localparam logic [2:0] NOTE_B4 = 3'b010;
    localparam logic [2:0] NOTE_C5 = 3'b111;

    typedef enum logic {SEQ_IDLE, SEQ_RUN} seq_state_t;

    typedef struct packed {
        logic       rest;
        logic [2:0] note;
    } pat_entry_t;

    localparam pat_entry_t PAT_RESET = '{rest: 1'b1, note: NOTE_C4};

endpackage

// File: rtl/seq_step_timer.sv
// Per-step cycle counter: flags the last cycle of a step and whether the
// upcoming cycle falls inside the gate window.
module seq_step_timer #(
    parameter int unsigned STEP_CYCLES = 6000000,
    parameter int unsigned GATE_CYCLES = 4500000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic step_tick,
    output logic gate_window
);

    localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign step_tick = (cnt_q == LAST);

    // Counter only advances while staying in RUN; entering or leaving RUN zeroes it.
    always_comb begin
        cnt_d = '0;
        if (run && !step_tick) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign gate_window = (32'(cnt_d) < 32'(GATE_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Programmable note-pattern sequencer feeding the note decoder / PWM path.
// Define SEQ_LOOP_EN to loop the pattern forever; otherwise it plays once.
module step_sequencer
    import seq_pkg::*;
#(
    parameter  int unsigned NUM_STEPS   = 8,
    parameter  int unsigned STEP_CYCLES = 6000000,
    parameter  int unsigned GATE_CYCLES = 4500000,
    localparam int unsigned IW          = $clog2(NUM_STEPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_step,
    input  logic [2:0]    wr_note,
    input  logic          wr_rest,
    output logic [2:0]    note,
    output logic          gate,
    output logic [IW-1:0] step_idx,
    output logic          playing
);

    localparam logic [IW-1:0] LAST_STEP = IW'(NUM_STEPS - 1);

    pat_entry_t    pat_q [NUM_STEPS];
    seq_state_t    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [2:0]    note_q, note_d;
    logic          rest_q, rest_d;
    logic          gate_q, gate_d;
    logic          playing_q;
    logic          latch;
    logic          run_c;
    logic          step_tick;
    logic          gate_window;

    seq_step_timer #(
        .STEP_CYCLES (STEP_CYCLES),
        .GATE_CYCLES (GATE_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .run         (run_c),
        .step_tick   (step_tick),
        .gate_window (gate_window)
    );

    // Pattern store; reads see the registered contents, so a write lands one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_STEPS); i++) begin
                pat_q[i] <= PAT_RESET;
            end
        end else if (wr_en) begin
            pat_q[wr_step] <= '{rest: wr_rest, note: wr_note};
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        note_d  = note_q;
        rest_d  = rest_q;
        latch   = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (start && !stop) begin
                    state_d = SEQ_RUN;
                    idx_d   = '0;
                    latch   = 1'b1;
                end
            end
            SEQ_RUN: begin
                if (stop) begin
                    state_d = SEQ_IDLE;
                    idx_d   = '0;
                end else if (step_tick) begin
                    if (idx_q == LAST_STEP) begin
`ifdef SEQ_LOOP_EN
                        idx_d = '0;
                        latch = 1'b1;
`else
                        state_d = SEQ_IDLE;
                        idx_d   = '0;
`endif
                    end else begin
                        idx_d = idx_q + IW'(1);
                        latch = 1'b1;
                    end
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
        if (latch) begin
            note_d = pat_q[idx_d].note;
            rest_d = pat_q[idx_d].rest;
        end
    end

    assign run_c  = (state_q == SEQ_RUN) && (state_d == SEQ_RUN);
    assign gate_d = (state_d == SEQ_RUN) && !rest_d && gate_window;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEQ_IDLE;
            idx_q     <= '0;
            note_q    <= NOTE_C4;
            rest_q    <= 1'b1;
            gate_q    <= 1'b0;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            note_q    <= note_d;
            rest_q    <= rest_d;
            gate_q    <= gate_d;
            playing_q <= (state_d == SEQ_RUN);
        end
    end

    assign note     = note_q;
    assign gate     = gate_q;
    assign step_idx = idx_q;
    assign playing  = playing_q;

endmodule
